// File: rtl/input_debouncer.sv
// ---------------------------------------------------------------------------
// input_debouncer
//
// Purpose:
//   Turns a raw, possibly bouncing single-bit input into a clean debounced
//   level plus one-cycle rise/fall/glitch strobes. A new level is accepted
//   only after the sampled input holds it for STABLE_CYCLES consecutive
//   clock edges. The debounced level drives the downstream edge and pulse
//   detectors.
//
// Parameters:
//   STABLE_CYCLES  consecutive samples needed to accept a new level (2..65535)
//
// Ports:
//   clk     in   sole clock, all logic on posedge
//   rst     in   synchronous active-high reset
//   a_raw   in   raw input level
//   a       out  debounced level (registered)
//   rise    out  one-cycle strobe when a goes 0->1 (registered)
//   fall    out  one-cycle strobe when a goes 1->0 (registered)
//   glitch  out  one-cycle strobe when a candidate change is abandoned
//
// Configuration macro:
//   INPUT_DEBOUNCER_SYNC_EN  when defined, a_raw passes through a 2-flop
//                            synchronizer (reset to 0) before the FSM, adding
//                            2 cycles of latency. When undefined, a_raw is
//                            assumed synchronous to clk and sampled directly.
// ---------------------------------------------------------------------------
module input_debouncer #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic a_raw,
  output logic a,
  output logic rise,
  output logic fall,
  output logic glitch
);

  // Counter only has to reach STABLE_CYCLES-1, so clog2 bits suffice;
  // at least one bit is kept so the smallest legal setting still builds.
  localparam int CW = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {
    STABLE_LOW  = 2'b00,
    ARM_HIGH    = 2'b01,
    STABLE_HIGH = 2'b10,
    ARM_LOW     = 2'b11
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          s;

`ifdef INPUT_DEBOUNCER_SYNC_EN
  logic [1:0] sync_q;

  // Two-flop synchronizer for inputs that are asynchronous to clk.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], a_raw};
    end
  end

  assign s = sync_q[1];
`else
  assign s = a_raw;
`endif

  // Debounce FSM. The strobes default low every edge so each one lasts
  // exactly one cycle. When the input reverts on the same edge that would
  // have completed acceptance, the revert is checked first, so the old
  // level wins and only glitch fires.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= STABLE_LOW;
      cnt    <= '0;
      a      <= 1'b0;
      rise   <= 1'b0;
      fall   <= 1'b0;
      glitch <= 1'b0;
    end else begin
      rise   <= 1'b0;
      fall   <= 1'b0;
      glitch <= 1'b0;
      case (state)
        STABLE_LOW: begin
          cnt <= '0;
          if (s) begin
            state <= ARM_HIGH;
            cnt   <= CW'(1);
          end
        end
        ARM_HIGH: begin
          if (!s) begin
            state  <= STABLE_LOW;
            cnt    <= '0;
            glitch <= 1'b1;
          end else if (cnt == CNT_LAST) begin
            state <= STABLE_HIGH;
            cnt   <= '0;
            a     <= 1'b1;
            rise  <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        STABLE_HIGH: begin
          cnt <= '0;
          if (!s) begin
            state <= ARM_LOW;
            cnt   <= CW'(1);
          end
        end
        ARM_LOW: begin
          if (s) begin
            state  <= STABLE_HIGH;
            cnt    <= '0;
            glitch <= 1'b1;
          end else if (cnt == CNT_LAST) begin
            state <= STABLE_LOW;
            cnt   <= '0;
            a     <= 1'b0;
            fall  <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          // Unreachable encodings recover to a known quiet state.
          state <= STABLE_LOW;
          cnt   <= '0;
          a     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_input_debouncer.sv
// ---------------------------------------------------------------------------
// tb_input_debouncer
//
// Purpose:
//   Self-checking bench for input_debouncer with STABLE_CYCLES=4 in the
//   default build (no synchronizer). Each table row is one clock edge:
//   inputs are driven on the falling edge and outputs are compared 1 time
//   unit after the following rising edge.
// ---------------------------------------------------------------------------
module tb_input_debouncer;

  logic clk;
  logic rst;
  logic a_raw;
  logic a;
  logic rise;
  logic fall;
  logic glitch;

  int check_count;
  int error_count;
  int step_num;

  typedef struct {
    string name;
    logic  rst;
    logic  a_raw;
    logic  exp_a;
    logic  exp_rise;
    logic  exp_fall;
    logic  exp_glitch;
  } vec_t;

  vec_t vecs[$];

  input_debouncer #(
    .STABLE_CYCLES(4)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .a_raw (a_raw),
    .a     (a),
    .rise  (rise),
    .fall  (fall),
    .glitch(glitch)
  );

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Queue one table row.
  task automatic addVec(input string name, input logic r, input logic in_v,
                        input logic ea, input logic er, input logic ef,
                        input logic eg);
    vec_t v;
    v.name       = name;
    v.rst        = r;
    v.a_raw      = in_v;
    v.exp_a      = ea;
    v.exp_rise   = er;
    v.exp_fall   = ef;
    v.exp_glitch = eg;
    vecs.push_back(v);
  endtask

  // Drive inputs away from the active edge, then wait for that edge and
  // settle before the outputs are sampled.
  task automatic applyStimulus(input logic r, input logic in_v);
    @(negedge clk);
    rst   = r;
    a_raw = in_v;
    @(posedge clk);
    #1;
    step_num++;
  endtask

  task automatic checkOne(input string name, input string sig,
                          input logic got, input logic exp);
    check_count++;
    if (got !== exp) begin
      error_count++;
      $display("[TB] FAIL %s.%s step %0d: got %b expected %b",
               name, sig, step_num, got, exp);
    end
  endtask

  task automatic checkOutput(input string name, input logic ea,
                             input logic er, input logic ef, input logic eg);
    checkOne(name, "a",      a,      ea);
    checkOne(name, "rise",   rise,   er);
    checkOne(name, "fall",   fall,   ef);
    checkOne(name, "glitch", glitch, eg);
  endtask

  // Apply one edge with inputs and expected outputs written inline.
  task automatic stepCheck(input string name, input logic r, input logic in_v,
                           input logic ea, input logic er, input logic ef,
                           input logic eg);
    applyStimulus(r, in_v);
    checkOutput(name, ea, er, ef, eg);
  endtask

  initial begin
    check_count = 0;
    error_count = 0;
    step_num    = 0;
    rst         = 1'b1;
    a_raw       = 1'b0;

    // Reset held 3 edges with a_raw high, then rise 4 edges after release.
    addVec("reset",      1, 1, 0, 0, 0, 0);
    addVec("reset",      1, 1, 0, 0, 0, 0);
    addVec("reset",      1, 1, 0, 0, 0, 0);
    addVec("post_rst",   0, 1, 0, 0, 0, 0);
    addVec("post_rst",   0, 1, 0, 0, 0, 0);
    addVec("post_rst",   0, 1, 0, 0, 0, 0);
    addVec("post_rst",   0, 1, 1, 1, 0, 0);
    addVec("hold_high",  0, 1, 1, 0, 0, 0);
    addVec("hold_high",  0, 1, 1, 0, 0, 0);
    // Clean 1->0 step.
    addVec("clean_fall", 0, 0, 1, 0, 0, 0);
    addVec("clean_fall", 0, 0, 1, 0, 0, 0);
    addVec("clean_fall", 0, 0, 1, 0, 0, 0);
    addVec("clean_fall", 0, 0, 0, 0, 1, 0);
    addVec("hold_low",   0, 0, 0, 0, 0, 0);
    // Clean 0->1 step: rise on 4th edge, cleared on the 5th.
    addVec("clean_rise", 0, 1, 0, 0, 0, 0);
    addVec("clean_rise", 0, 1, 0, 0, 0, 0);
    addVec("clean_rise", 0, 1, 0, 0, 0, 0);
    addVec("clean_rise", 0, 1, 1, 1, 0, 0);
    addVec("clean_rise", 0, 1, 1, 0, 0, 0);
    addVec("to_low",     0, 0, 1, 0, 0, 0);
    addVec("to_low",     0, 0, 1, 0, 0, 0);
    addVec("to_low",     0, 0, 1, 0, 0, 0);
    addVec("to_low",     0, 0, 0, 0, 1, 0);
    addVec("to_low",     0, 0, 0, 0, 0, 0);
    // Bounce 1,0,1,1,0,1,1,1,1: glitch on 2nd and 5th, rise on 9th.
    addVec("bounce",     0, 1, 0, 0, 0, 0);
    addVec("bounce",     0, 0, 0, 0, 0, 1);
    addVec("bounce",     0, 1, 0, 0, 0, 0);
    addVec("bounce",     0, 1, 0, 0, 0, 0);
    addVec("bounce",     0, 0, 0, 0, 0, 1);
    addVec("bounce",     0, 1, 0, 0, 0, 0);
    addVec("bounce",     0, 1, 0, 0, 0, 0);
    addVec("bounce",     0, 1, 0, 0, 0, 0);
    addVec("bounce",     0, 1, 1, 1, 0, 0);
    addVec("bounce",     0, 1, 1, 0, 0, 0);
    addVec("to_low2",    0, 0, 1, 0, 0, 0);
    addVec("to_low2",    0, 0, 1, 0, 0, 0);
    addVec("to_low2",    0, 0, 1, 0, 0, 0);
    addVec("to_low2",    0, 0, 0, 0, 1, 0);
    addVec("to_low2",    0, 0, 0, 0, 0, 0);
    // Late abort: high on 3 edges, low on the 4th -> glitch, a stays 0.
    addVec("late_abort", 0, 1, 0, 0, 0, 0);
    addVec("late_abort", 0, 1, 0, 0, 0, 0);
    addVec("late_abort", 0, 1, 0, 0, 0, 0);
    addVec("late_abort", 0, 0, 0, 0, 0, 1);
    addVec("late_abort", 0, 0, 0, 0, 0, 0);
    // Single-sample low excursion while high -> glitch, a stays 1.
    addVec("to_high",    0, 1, 0, 0, 0, 0);
    addVec("to_high",    0, 1, 0, 0, 0, 0);
    addVec("to_high",    0, 1, 0, 0, 0, 0);
    addVec("to_high",    0, 1, 1, 1, 0, 0);
    addVec("spike_low",  0, 1, 1, 0, 0, 0);
    addVec("spike_low",  0, 0, 1, 0, 0, 0);
    addVec("spike_low",  0, 1, 1, 0, 0, 1);
    addVec("spike_low",  0, 1, 1, 0, 0, 0);
    // Late abort on the high side: low 3 edges, back high on the 4th.
    addVec("abort_hi",   0, 0, 1, 0, 0, 0);
    addVec("abort_hi",   0, 0, 1, 0, 0, 0);
    addVec("abort_hi",   0, 0, 1, 0, 0, 0);
    addVec("abort_hi",   0, 1, 1, 0, 0, 1);
    addVec("abort_hi",   0, 1, 1, 0, 0, 0);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].rst, vecs[i].a_raw);
      checkOutput(vecs[i].name, vecs[i].exp_a, vecs[i].exp_rise,
                  vecs[i].exp_fall, vecs[i].exp_glitch);
    end

    // Reset while a=1: a drops at once with no fall strobe.
    stepCheck("rst_high",  1, 1, 0, 0, 0, 0);
    // Input still high after release: full 4-edge qualification again.
    stepCheck("rst_rearm", 0, 1, 0, 0, 0, 0);
    stepCheck("rst_rearm", 0, 1, 0, 0, 0, 0);
    stepCheck("rst_rearm", 0, 1, 0, 0, 0, 0);
    stepCheck("rst_rearm", 0, 1, 1, 1, 0, 0);
    stepCheck("rst_rearm", 0, 1, 1, 0, 0, 0);

    // Reset while armed (low side after a high-side arm is discarded).
    stepCheck("rst_armed", 1, 0, 0, 0, 0, 0);
    stepCheck("rst_armed", 0, 0, 0, 0, 0, 0);
    stepCheck("rst_armed", 0, 1, 0, 0, 0, 0);
    stepCheck("rst_armed", 0, 1, 0, 0, 0, 0);
    // Reset while armed high: the armed change vanishes silently.
    stepCheck("rst_armed", 1, 1, 0, 0, 0, 0);
    stepCheck("rst_armed", 0, 0, 0, 0, 0, 0);
    stepCheck("rst_armed", 0, 0, 0, 0, 0, 0);
    // Counter starts fresh after the reset.
    stepCheck("rst_fresh", 0, 1, 0, 0, 0, 0);
    stepCheck("rst_fresh", 0, 1, 0, 0, 0, 0);
    stepCheck("rst_fresh", 0, 1, 0, 0, 0, 0);
    stepCheck("rst_fresh", 0, 1, 1, 1, 0, 0);
    stepCheck("rst_fresh", 0, 1, 1, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", error_count, check_count);
    $finish;
  end

endmodule

// File: doc/input_debouncer.md
# input_debouncer

Conditions a raw, possibly bouncing single-bit input into a clean level plus single-cycle edge and glitch strobes. Sits directly upstream of the posedge and one-cycle-pulse (010) detectors and drives their `a` input. Debouncing uses a four-state FSM and a stability counter. A raw change is accepted only after it holds for `STABLE_CYCLES` consecutive clock edges.

## Interface
- `STABLE_CYCLES`, default 4: consecutive samples needed to accept a new level. Legal range 2..65535.
- Counter width is `$clog2(STABLE_CYCLES)`, minimum 1. It is derived, not a parameter.
- `clk`  in  1  sole clock; all logic on posedge.
- `rst`  in  1  reset, synchronous and active-high.
- `a_raw`  in  1  raw input level.
- `a`  out  1  debounced level; feeds the downstream detectors.
- `rise`  out  1  one-cycle strobe when `a` goes 0→1.
- `fall`  out  1  one-cycle strobe when `a` goes 1→0.
- `glitch`  out  1  one-cycle strobe when a candidate change is abandoned before acceptance.

## Operation
- `s` is the sampled input: the synchronizer output if `INPUT_DEBOUNCER_SYNC_EN` is defined, otherwise `a_raw` directly.
- FSM states: STABLE_LOW, ARM_HIGH, STABLE_HIGH, ARM_LOW.
- STABLE_LOW:
  - `s`=1 → ARM_HIGH, cnt←1.
  - Otherwise stay.
- ARM_HIGH:
  - `s`=0 → STABLE_LOW, `glitch`←1.
  - `s`=1 and cnt==STABLE_CYCLES-1 → STABLE_HIGH, `a`←1, `rise`←1, cnt←0.
  - `s`=1 otherwise → cnt←cnt+1.
- STABLE_HIGH and ARM_LOW mirror the above with polarity swapped:
  - `s`=0 arms.
  - Return to 1 → `glitch`, back to STABLE_HIGH.
  - Acceptance → `a`←0, `fall`←1.
- Counter:
  - Never exceeds STABLE_CYCLES-1; no wrap-around.
  - Cleared on every return to a STABLE state.
- `rise`, `fall` and `glitch` are mutually exclusive. Each is high for exactly one cycle, then cleared on the next edge unless re-set.
- `a` changes only in the same cycle as `rise` or `fall`.
- Illegal or unused state encoding → STABLE_LOW next edge, no strobes.
- Reset values: `a`=0, `rise`=0, `fall`=0, `glitch`=0, state STABLE_LOW, cnt=0, synchronizer flops 0.
- Reset mid-operation:
  - Any armed change is discarded with no `glitch`.
  - A high `a` is forced to 0 with no `fall` strobe.

## Timing
- All outputs are registered; there is no combinational path from `a_raw` to any output.
- Latency without the macro:
  - `a_raw` is sampled at new value on edges k, k+1, …, k+STABLE_CYCLES-1.
  - `a` and the strobe update at edge k+STABLE_CYCLES-1, visible after it.
- With the macro, add 2 cycles.
- A single-sample excursion produces `glitch` on the next edge. `a` stays unchanged.
- Toggle arriving in the same edge that would complete acceptance: the old value wins.
  - Example: in ARM_HIGH with cnt==STABLE_CYCLES-1 and `s`=0 → `glitch`, no `rise`.
- After `rst` deasserts with `a_raw` held 1: `rise` occurs STABLE_CYCLES edges later (+2 with the macro).
- Minimum spacing between `rise` and the following `fall` is STABLE_CYCLES cycles.
- `rise` followed by `fall` STABLE_CYCLES cycles later, with `a` high between them, is the minimal clean pulse presented downstream.

## Configuration
- `INPUT_DEBOUNCER_SYNC_EN` defined:
  - Inserts a 2-flop synchronizer on `a_raw`, reset to 0.
  - Use for asynchronous pins.
  - Adds 2 cycles of latency to every response.
- Not defined: `a_raw` is treated as already synchronous to `clk` and sampled directly. No extra flops.

## Test plan
All scenarios use STABLE_CYCLES=4 and the macro undefined unless stated.
- Reset: hold `rst`=1 for 3 cycles with `a_raw`=1 → `a`=0, `rise`=`fall`=`glitch`=0 throughout. After release, `rise` appears 4 edges later.
- Clean step: `a_raw` 0→1 sampled at edge 10 and held → `a`=1 and `rise`=1 after edge 13, `rise`=0 after edge 14. A later clean 1→0 step gives `fall` symmetrically.
- Bounce: `a_raw` pattern 1,0,1,1,0,1,1,1,1 from edge 20 → `glitch` after edges 21 and 24. `rise` after edge 28 only.
- Late abort: `a_raw` high on 3 edges, low on the 4th → `glitch`, no `rise`, `a` stays 0.
- Reset mid-operation: `rst` pulsed while `a`=1 → `a`=0 next cycle, no `fall`. While armed → no `glitch`.
- Macro defined: clean step sampled at edge 10 → `rise` after edge 15. Single-cycle `a_raw` spike → `glitch` only, delayed by 2 cycles.
